// File: rtl/tcdm_sram_responder.sv
// rtl/tcdm_sram_responder.sv - TCDM responder fronting a single-port SRAM with error logging
module tcdm_sram_responder #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h1C00_0000,
  parameter int                    MEM_WORDS    = 4096,
  parameter int                    SRAM_LATENCY = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         req_i,
  input  logic [ADDR_WIDTH-1:0]        add_i,
  input  logic                         wen_i,
  input  logic [31:0]                  wdata_i,
  input  logic [3:0]                   be_i,
  output logic                         gnt_o,
  output logic                         r_valid_o,
  output logic [31:0]                  r_rdata_o,
  output logic                         r_opc_o,
  input  logic                         stall_i,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
  output logic [31:0]                  mem_wdata_o,
  output logic [3:0]                   mem_be_o,
  input  logic [31:0]                  mem_rdata_i,
  input  logic                         err_clear_i,
  output logic [15:0]                  err_count_o,
  output logic [ADDR_WIDTH-1:0]        err_addr_o,
  output logic                         err_valid_o
);

  localparam int MEM_AW = $clog2(MEM_WORDS);
  localparam int LAST   = SRAM_LATENCY - 1;
  // One extra bit so the window end cannot wrap past the top of the address space
  localparam logic [ADDR_WIDTH:0] END_ADDR =
    {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(MEM_WORDS * 4);
  localparam logic [31:0] ERR_DATA = 32'hBADA_CCE5;

  logic                  in_range;
  logic                  err_event;
  logic [ADDR_WIDTH-1:0] offset;

  logic [SRAM_LATENCY-1:0] pipe_valid;
  logic [SRAM_LATENCY-1:0] pipe_read;
  logic [SRAM_LATENCY-1:0] pipe_err;

  assign gnt_o     = req_i & ~stall_i;
  assign in_range  = ({1'b0, add_i} >= {1'b0, BASE_ADDR}) && ({1'b0, add_i} < END_ADDR);
  assign err_event = gnt_o & ~in_range;
  assign offset    = add_i - BASE_ADDR;

  assign mem_req_o   = gnt_o & in_range;
  assign mem_we_o    = ~wen_i;
  assign mem_addr_o  = MEM_AW'(offset >> 2);
  assign mem_wdata_o = wdata_i;
  assign mem_be_o    = be_i;

  // Response shift register: one slot per grant, read data arrives from the SRAM at the last stage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_valid <= '0;
      pipe_read  <= '0;
      pipe_err   <= '0;
    end else begin
      pipe_valid[0] <= gnt_o;
      pipe_read[0]  <= wen_i;
      pipe_err[0]   <= ~in_range;
      for (int i = 1; i < SRAM_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_read[i]  <= pipe_read[i-1];
        pipe_err[i]   <= pipe_err[i-1];
      end
    end
  end

  always_comb begin
    r_valid_o = pipe_valid[LAST];
    r_opc_o   = 1'b0;
    r_rdata_o = '0;
    if (pipe_valid[LAST]) begin
      if (pipe_err[LAST]) begin
        r_opc_o   = 1'b1;
        r_rdata_o = ERR_DATA;
      end else if (pipe_read[LAST]) begin
        r_rdata_o = mem_rdata_i;
      end
    end
  end

  // Clear wins over a same-cycle error; first captured address is kept until cleared
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_count_o <= '0;
      err_addr_o  <= '0;
      err_valid_o <= 1'b0;
    end else if (err_clear_i) begin
      err_count_o <= '0;
      err_addr_o  <= '0;
      err_valid_o <= 1'b0;
    end else if (err_event) begin
      if (err_count_o != 16'hFFFF) err_count_o <= err_count_o + 16'd1;
      if (!err_valid_o) begin
        err_addr_o  <= add_i;
        err_valid_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tcdm_sram_responder.sv
// tb/tb_tcdm_sram_responder.sv - directed bench for tcdm_sram_responder at SRAM latency 1 and 3
module tb_tcdm_sram_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, wen, stall, err_clear;
  logic [31:0] add, wdata;
  logic [3:0]  be;

  logic        gnt_a, rv_a, opc_a, mreq_a, mwe_a, ev_a;
  logic [31:0] rd_a, mwd_a, mrd_a, ea_a;
  logic [11:0] maddr_a;
  logic [3:0]  mbe_a;
  logic [15:0] ec_a;

  logic        gnt_b, rv_b, opc_b, mreq_b, mwe_b, ev_b;
  logic [31:0] rd_b, mwd_b, mrd_b, ea_b;
  logic [11:0] maddr_b;
  logic [3:0]  mbe_b;
  logic [15:0] ec_b;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tcdm_sram_responder #(.SRAM_LATENCY(1)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt_a), .r_valid_o(rv_a), .r_rdata_o(rd_a),
    .r_opc_o(opc_a), .stall_i(stall), .mem_req_o(mreq_a), .mem_we_o(mwe_a),
    .mem_addr_o(maddr_a), .mem_wdata_o(mwd_a), .mem_be_o(mbe_a), .mem_rdata_i(mrd_a),
    .err_clear_i(err_clear), .err_count_o(ec_a), .err_addr_o(ea_a), .err_valid_o(ev_a)
  );

  tcdm_sram_responder #(.SRAM_LATENCY(3)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt_b), .r_valid_o(rv_b), .r_rdata_o(rd_b),
    .r_opc_o(opc_b), .stall_i(stall), .mem_req_o(mreq_b), .mem_we_o(mwe_b),
    .mem_addr_o(maddr_b), .mem_wdata_o(mwd_b), .mem_be_o(mbe_b), .mem_rdata_i(mrd_b),
    .err_clear_i(err_clear), .err_count_o(ec_b), .err_addr_o(ea_b), .err_valid_o(ev_b)
  );

  // Behavioural SRAMs: latency 1 for instance a, latency 3 for instance b
  logic [31:0] mem_a [0:4095];
  logic [31:0] mem_b [0:4095];
  logic [31:0] rdq_b0, rdq_b1, rdq_b2;

  always @(posedge clk) begin
    if (mreq_a) begin
      if (mwe_a) begin
        for (int k = 0; k < 4; k++) if (mbe_a[k]) mem_a[maddr_a][k*8 +: 8] <= mwd_a[k*8 +: 8];
      end else begin
        mrd_a <= mem_a[maddr_a];
      end
    end
  end

  always @(posedge clk) begin
    if (mreq_b) begin
      if (mwe_b) begin
        for (int k = 0; k < 4; k++) if (mbe_b[k]) mem_b[maddr_b][k*8 +: 8] <= mwd_b[k*8 +: 8];
      end else begin
        rdq_b0 <= mem_b[maddr_b];
      end
    end
    rdq_b1 <= rdq_b0;
    rdq_b2 <= rdq_b1;
  end
  assign mrd_b = rdq_b2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  initial begin
    rst_n = 1'b0; req = 1'b0; wen = 1'b1; stall = 1'b0; err_clear = 1'b0;
    add = '0; wdata = '0; be = 4'h0;
    tick(); tick();
    chk("rst_rvalid_a", rv_a, 0);
    chk("rst_rvalid_b", rv_b, 0);
    chk("rst_rdata_a", rd_a, 0);
    chk("rst_opc_a", opc_a, 0);
    chk("rst_memreq_a", mreq_a, 0);
    chk("rst_errcnt_a", ec_a, 0);
    chk("rst_erraddr_a", ea_a, 0);
    chk("rst_errvalid_a", ev_a, 0);
    req = 1'b1;
    #1 chk("rst_gnt_follows_req", gnt_a, 1);
    req = 1'b0;
    #1 chk("rst_gnt_low", gnt_a, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();

    // Write then read 0x1C00_0010
    req = 1'b1; add = 32'h1C00_0010; wen = 1'b0; wdata = 32'hDEAD_BEEF; be = 4'hF;
    #1;
    chk("wr_gnt", gnt_a, 1);
    chk("wr_memreq", mreq_a, 1);
    chk("wr_memwe", mwe_a, 1);
    chk("wr_memaddr", maddr_a, 4);
    chk("wr_memwdata", mwd_a, 32'hDEAD_BEEF);
    chk("wr_membe", mbe_a, 4'hF);
    tick();
    wen = 1'b1; wdata = '0;
    #1;
    chk("wr_rsp_valid_a", rv_a, 1);
    chk("wr_rsp_opc_a", opc_a, 0);
    chk("wr_rsp_rdata_a", rd_a, 0);
    chk("wr_rsp_valid_b_early", rv_b, 0);
    chk("rd_memwe", mwe_a, 0);
    chk("rd_memaddr", maddr_a, 4);
    tick();
    req = 1'b0;
    #1;
    chk("rd_rsp_valid_a", rv_a, 1);
    chk("rd_rsp_rdata_a", rd_a, 32'hDEAD_BEEF);
    chk("rd_rsp_opc_a", opc_a, 0);
    chk("wr_rsp_valid_b_n2", rv_b, 0);
    tick();
    chk("wr_rsp_valid_b", rv_b, 1);
    chk("wr_rsp_rdata_b", rd_b, 0);
    chk("idle_valid_a", rv_a, 0);
    tick();
    chk("rd_rsp_valid_b", rv_b, 1);
    chk("rd_rsp_rdata_b", rd_b, 32'hDEAD_BEEF);
    tick();
    chk("drain_valid_b", rv_b, 0);

    // Preload 8 words, then 8 back-to-back reads
    for (int i = 0; i < 8; i++) begin
      req = 1'b1; wen = 1'b0; be = 4'hF; add = 32'h1C00_0100 + 32'(4 * i); wdata = pat(i);
      tick();
    end
    req = 1'b0; wen = 1'b1;
    tick(); tick(); tick(); tick();
    for (int t = 0; t < 11; t++) begin
      if (t < 8) begin
        req = 1'b1; add = 32'h1C00_0100 + 32'(4 * t);
        #1 chk("b2b_gnt", gnt_b, 1);
      end else begin
        req = 1'b0;
      end
      tick();
      chk($sformatf("b2b_valid_a_%0d", t), rv_a, (t < 8) ? 1 : 0);
      chk($sformatf("b2b_rdata_a_%0d", t), rd_a, (t < 8) ? pat(t) : 0);
      chk($sformatf("b2b_valid_b_%0d", t), rv_b, (t >= 2 && t < 10) ? 1 : 0);
      chk($sformatf("b2b_rdata_b_%0d", t), rd_b, (t >= 2 && t < 10) ? pat(t - 2) : 0);
    end

    // Range boundaries, combinational only (no clock edge while req is up)
    req = 1'b1; wen = 1'b1; add = 32'h1C00_3FFC;
    #1;
    chk("last_word_memreq", mreq_a, 1);
    chk("last_word_memaddr", maddr_a, 12'hFFF);
    add = 32'h1BFF_FFFC;
    #1 chk("below_base_memreq", mreq_a, 0);
    req = 1'b0;
    #1;

    // Out-of-range read, then out-of-range write at 0x0
    req = 1'b1; wen = 1'b1; add = 32'h1C00_4000;
    #1;
    chk("oor_gnt", gnt_a, 1);
    chk("oor_memreq", mreq_a, 0);
    tick();
    wen = 1'b0; add = 32'h0; wdata = 32'h1234_5678;
    #1;
    chk("oor_valid_a", rv_a, 1);
    chk("oor_opc_a", opc_a, 1);
    chk("oor_rdata_a", rd_a, 32'hBADA_CCE5);
    chk("oor_errcnt1", ec_a, 1);
    chk("oor_erraddr1", ea_a, 32'h1C00_4000);
    chk("oor_errvalid1", ev_a, 1);
    chk("oor0_memreq", mreq_a, 0);
    tick();
    req = 1'b0; wen = 1'b1;
    #1;
    chk("oor_wr_opc_a", opc_a, 1);
    chk("oor_wr_rdata_a", rd_a, 32'hBADA_CCE5);
    chk("oor_errcnt2", ec_a, 2);
    chk("oor_erraddr2", ea_a, 32'h1C00_4000);
    chk("oor_errcnt2_b", ec_b, 2);
    tick();
    chk("oor_valid_b", rv_b, 1);
    chk("oor_opc_b", opc_b, 1);
    chk("oor_rdata_b", rd_b, 32'hBADA_CCE5);
    tick();
    chk("oor_wr_opc_b", opc_b, 1);
    tick(); tick();

    // Stall with request held
    req = 1'b1; wen = 1'b1; add = 32'h1C00_0010; stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("stall_gnt", gnt_a, 0);
      chk("stall_memreq", mreq_a, 0);
      tick();
      chk("stall_no_rsp", rv_a, 0);
    end
    stall = 1'b0;
    #1;
    chk("unstall_gnt", gnt_a, 1);
    chk("unstall_memreq", mreq_a, 1);
    tick();
    req = 1'b0;
    #1;
    chk("unstall_rsp_a", rv_a, 1);
    chk("unstall_rdata_a", rd_a, 32'hDEAD_BEEF);
    tick(); tick();
    chk("unstall_rsp_b", rv_b, 1);
    chk("unstall_rdata_b", rd_b, 32'hDEAD_BEEF);
    tick();

    // Error counter saturation and clear priority
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("clear_cnt", ec_a, 0);
    chk("clear_valid", ev_a, 0);
    chk("clear_addr", ea_a, 0);
    req = 1'b1; wen = 1'b1; add = 32'h2000_0000;
    repeat (65535) tick();
    chk("sat_cnt", ec_a, 16'hFFFF);
    chk("sat_addr", ea_a, 32'h2000_0000);
    chk("sat_valid", ev_a, 1);
    add = 32'h3000_0000;
    tick();
    chk("sat_hold_cnt", ec_a, 16'hFFFF);
    chk("sat_first_wins", ea_a, 32'h2000_0000);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0; req = 1'b0;
    chk("clr_prio_cnt", ec_a, 0);
    chk("clr_prio_valid", ev_a, 0);
    chk("clr_prio_addr", ea_a, 0);
    chk("clr_prio_cnt_b", ec_b, 0);
    tick(); tick(); tick(); tick();

    // Reset with two responses in flight on instance b
    req = 1'b1; wen = 1'b1; add = 32'h1C00_4000;
    tick();
    add = 32'h1C00_0010;
    tick();
    req = 1'b0;
    chk("pre_rst_errcnt_b", ec_b, 1);
    chk("pre_rst_valid_a", rv_a, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid_a", rv_a, 0);
    chk("async_rst_valid_b", rv_b, 0);
    chk("async_rst_errcnt_b", ec_b, 0);
    chk("async_rst_errvalid_b", ev_b, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      tick();
      chk($sformatf("post_rst_valid_a_%0d", r), rv_a, 0);
      chk($sformatf("post_rst_valid_b_%0d", r), rv_b, 0);
      chk($sformatf("post_rst_rdata_b_%0d", r), rd_b, 0);
    end
    chk("post_rst_erraddr_b", ea_b, 0);
    chk("post_rst_memreq_b", mreq_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tcdm_sram_responder.md
# tcdm_sram_responder

Responder (slave) end of the XBAR_TCDM_BUS request/grant/r_valid protocol used by the fabric-controller core's instruction and data ports. Accepts TCDM requests, grants them the same cycle unless stalled, drives a single-port SRAM macro, and returns in-order responses after a fixed pipeline latency. Out-of-range accesses are never sent to the SRAM; they return an error response (r_opc) at the same latency and are logged.

## Interface
- ADDR_WIDTH, 32, request address width
- BASE_ADDR, 32'h1C00_0000, byte address of SRAM word 0; word-aligned
- MEM_WORDS, 4096, SRAM depth in 32-bit words; power of two, ≥ 2
- SRAM_LATENCY, 1, cycles from mem_req_o to valid mem_rdata_i; legal 1..3
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  TCDM request
- add_i  in  ADDR_WIDTH  byte address; add_i[1:0] ignored
- wen_i  in  1  1 = read, 0 = write
- wdata_i  in  32  write data
- be_i  in  4  byte enables
- gnt_o  out  1  request accepted this cycle
- r_valid_o  out  1  response valid (reads and writes)
- r_rdata_o  out  32  read data
- r_opc_o  out  1  1 = error response
- stall_i  in  1  blocks grants (arbitration/scrub)
- mem_req_o  out  1  SRAM access
- mem_we_o  out  1  SRAM write enable (active high)
- mem_addr_o  out  $clog2(MEM_WORDS)  SRAM word address
- mem_wdata_o  out  32  SRAM write data
- mem_be_o  out  4  SRAM byte enables
- mem_rdata_i  in  32  SRAM read data
- err_clear_i  in  1  clears error log
- err_count_o  out  16  saturating count of error responses
- err_addr_o  out  ADDR_WIDTH  add_i of first error since reset/clear
- err_valid_o  out  1  err_addr_o holds a captured address

## Operation
- gnt_o = req_i & ~stall_i (combinational). Requestor must hold req/add/wen/wdata/be until gnt.
- In range: BASE_ADDR ≤ add_i < BASE_ADDR + 4·MEM_WORDS, unsigned ADDR_WIDTH compare, no wrap.
- Granted in-range request: mem_req_o=1 same cycle, mem_we_o=~wen_i, mem_addr_o=(add_i−BASE_ADDR)>>2, mem_wdata_o=wdata_i, mem_be_o=be_i. Otherwise mem_req_o=0 and other mem_* outputs are don't-care.
- Granted out-of-range request: no SRAM access; error response queued.
- Response pipeline: SRAM_LATENCY-deep shift register carrying {valid, is_read, err}. One entry per grant; back-to-back grants every cycle allowed; responses strictly in grant order.
- Response data: read OK → r_rdata_o=mem_rdata_i, r_opc_o=0; write OK → r_rdata_o=0, r_opc_o=0; error (read or write) → r_rdata_o=32'hBADA_CCE5, r_opc_o=1.
- r_rdata_o/r_opc_o are 0 whenever r_valid_o=0.
- Error log: on each granted out-of-range request, err_count_o increments, saturating at 16'hFFFF; if err_valid_o=0, err_addr_o←add_i and err_valid_o←1 (first error wins).
- err_clear_i: next cycle err_count_o=0, err_valid_o=0, err_addr_o=0; clear takes priority over a simultaneous error (that error is not logged).

## Timing
- Reset values: gnt_o follows req_i&~stall_i; r_valid_o=0, r_rdata_o=0, r_opc_o=0, mem_req_o=0, err_count_o=0, err_addr_o=0, err_valid_o=0; pipeline flushed.
- Grant at cycle N → r_valid_o=1 exactly at cycle N+SRAM_LATENCY, independent of stall_i and of the error path.
- Reset asserted mid-operation: all in-flight responses discarded; no r_valid_o after rst_ni deasserts until a new grant.
- stall_i only blocks new grants; in-flight responses still complete.
- No response backpressure: requestor must always accept r_valid_o.

## Test plan
- SRAM_LATENCY=1: write 32'hDEADBEEF, be=4'hF to 0x1C00_0010; read same → write rsp at N+1 r_opc=0 rdata=0; read rsp rdata=32'hDEADBEEF, mem_addr_o=4.
- Back-to-back 8 reads, one grant per cycle, SRAM_LATENCY=3 → 8 consecutive r_valid cycles starting 3 cycles after first grant, data in order.
- Read 0x1C00_4000 (one past end, MEM_WORDS=4096) → mem_req_o=0, r_opc=1, rdata=32'hBADACCE5, err_count=1, err_addr=0x1C00_4000, err_valid=1; second error at 0x0 → count=2, err_addr unchanged.
- stall_i high 3 cycles with req_i held → gnt_o=0, no mem_req_o, then grant on stall release, response SRAM_LATENCY later.
- Force err_count to 16'hFFFF via errors, one more error → stays 16'hFFFF; err_clear_i with simultaneous error → count=0, err_valid=0.
- Assert rst_ni low with 2 responses in flight → no r_valid_o after reset release; outputs at reset values.
